// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: state encoding,
// converter operand/result widths and a width helper.
package bcd_arb_pkg;

  localparam int BIN_W_DEF = 12;
  localparam int BCD_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_GRANT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  // ceil(log2(n)), never less than 1 so a 1-entry range still gets a bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the pointer and
// wraps; the first asserted request wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  // walk candidates ptr+1 .. ptr+N (mod N), keep the first hit
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one bin->BCD converter among NUM_REQ requesters. Grants round-robin,
// pulses the converter start, waits (bounded by a watchdog) for its done
// pulse and returns the result to the granted requester.
//
//  state | meaning
//  FLUSH | converter may be mid-conversion (no reset); wait for rdy or watchdog
//  IDLE  | waiting for any request; pick winner, latch its operand
//  GRANT | 1 cycle: conv_en + req_ready to winner, watchdog cleared
//  WAIT  | converter running; watchdog counts, timeout aborts with error
//  RESP  | 1 cycle: rsp_valid to winner; timeout sends us back through FLUSH
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int BCD_W   = BCD_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [BCD_W-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     conv_en,
  output logic [BIN_W-1:0]         conv_bin,
  input  logic [BCD_W-1:0]         conv_bcd,
  input  logic                     conv_rdy,
  output logic                     busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int WW = clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [IW-1:0]      idx_q,   idx_d;
  logic [IW-1:0]      ptr_q,   ptr_d;
  logic [WW-1:0]      wd_q,    wd_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;
  logic [BCD_W-1:0]   data_q,  data_d;
  logic               err_q,   err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [WW-1:0]      wd_inc;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

  // next-state and datapath updates; everything holds unless a state moves it
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    bin_d   = bin_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_FLUSH: begin
        if (conv_rdy || (wd_q == WD_MAX)) begin
          state_d = ST_IDLE;
          wd_d    = '0;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          bin_d   = req_data[int'(arb_idx)*BIN_W +: BIN_W];
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // a done pulse on the timeout cycle still counts as success
        if (conv_rdy) begin
          data_d  = conv_bcd;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_q == WD_MAX) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_RESP: begin
        ptr_d   = idx_q;
        wd_d    = '0;
        state_d = err_q ? ST_FLUSH : ST_IDLE;
      end
      default: begin
        state_d = ST_FLUSH;
        wd_d    = '0;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FLUSH;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      wd_q    <= '0;
      bin_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      bin_q   <= bin_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign conv_en   = (state_q == ST_GRANT);
  assign req_ready = (state_q == ST_GRANT) ? gnt_q : '0;
  assign rsp_valid = (state_q == ST_RESP)  ? gnt_q : '0;
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  assign conv_bin  = bin_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter with a behavioural bin->BCD converter whose
// latency and done pulse can be steered per scenario.
module tb_bcd_conv_arbiter;

  localparam int NR = 4;
  localparam int BW = 12;
  localparam int DW = 16;
  localparam int TO = 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*BW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            conv_en;
  logic [BW-1:0]   conv_bin;
  logic [DW-1:0]   conv_bcd = '0;
  logic            conv_rdy = 1'b0;
  logic            busy;

  bcd_conv_arbiter #(
    .NUM_REQ (NR),
    .BIN_W   (BW),
    .BCD_W   (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .conv_en   (conv_en),
    .conv_bin  (conv_bin),
    .conv_bcd  (conv_bcd),
    .conv_rdy  (conv_rdy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [BW-1:0] bin; } gnt_t;
  typedef struct { int idx; logic [DW-1:0] bcd; logic err; } rsp_t;

  gnt_t gq[$];
  rsp_t eq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int rsp_cyc = 0;
  int n_conv_en = 0;
  int t0 = 0;
  logic [NR-1:0] sticky = '0;
  logic [NR-1:0] drop = '0;

  int  mdl_lat = 63;
  bit  mdl_never = 1'b0;
  logic          m_busy = 1'b0;
  int            m_cnt = 0;
  logic [BW-1:0] m_opnd = '0;

  function automatic logic [DW-1:0] bin2bcd(input logic [BW-1:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // converter model: no reset, starts on conv_en, pulses rdy mdl_lat edges later
  always @(posedge clk) begin
    conv_rdy <= 1'b0;
    if (conv_en) begin
      m_busy <= 1'b1;
      m_cnt  <= mdl_lat;
      m_opnd <= conv_bin;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        if (!mdl_never) begin
          conv_rdy <= 1'b1;
          conv_bcd <= bin2bcd(m_opnd);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic exp_grant(input int i, input logic [BW-1:0] bin);
    gnt_t g;
    g.idx = i;
    g.bin = bin;
    gq.push_back(g);
  endtask

  task automatic exp_rsp(input int i, input logic [DW-1:0] bcd, input logic err);
    rsp_t r;
    r.idx = i;
    r.bcd = bcd;
    r.err = err;
    eq.push_back(r);
  endtask

  task automatic raise(input int i, input logic [BW-1:0] bin);
    req_data[i*BW +: BW] = bin;
    req_valid[i] = 1'b1;
  endtask

  task automatic monitor();
    gnt_t g;
    rsp_t r;
    if (conv_en) n_conv_en++;
    if (conv_en || (req_ready != '0)) begin
      gnt_cyc = cyc;
      if (gq.size() == 0) begin
        check_eq("grant_unexpected", 32'({conv_en, req_ready}), 32'd0);
      end else begin
        g = gq.pop_front();
        check_eq("grant_onehot", 32'(req_ready), 32'd1 << g.idx);
        check_eq("grant_conv_en", 32'(conv_en), 32'd1);
        check_eq("grant_conv_bin", 32'(conv_bin), 32'(g.bin));
      end
    end
    if (rsp_valid != '0) begin
      rsp_cyc = cyc;
      if (eq.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        r = eq.pop_front();
        check_eq("rsp_onehot", 32'(rsp_valid), 32'd1 << r.idx);
        check_eq("rsp_data", 32'(rsp_data), 32'(r.bcd));
        check_eq("rsp_err", 32'(rsp_err), 32'(r.err));
      end
    end
  endtask

  // sample at negedge, retire accepted requests just after the next posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    drop = req_ready & ~sticky;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~drop;
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n;
    n = 0;
    while (((gq.size() != 0) || (eq.size() != 0) || busy) && (n < budget)) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(gq.size() + eq.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_conv_en", 32'(conv_en), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    check_eq("flush_busy_after_reset", 32'(busy), 32'd1);

    // all four requesters valid together: order 0,1,2,3 from reset pointer
    n_conv_en = 0;
    raise(0, 12'h000); raise(1, 12'h009); raise(2, 12'h3E7); raise(3, 12'h064);
    exp_grant(0, 12'h000); exp_rsp(0, 16'h0000, 1'b0);
    exp_grant(1, 12'h009); exp_rsp(1, 16'h0009, 1'b0);
    exp_grant(2, 12'h3E7); exp_rsp(2, 16'h0999, 1'b0);
    exp_grant(3, 12'h064); exp_rsp(3, 16'h0100, 1'b0);
    run_until_drained("drain_all4", 3000);
    check_eq("all4_conv_en_count", 32'(n_conv_en), 32'd4);
    check_eq("idle_not_busy", 32'(busy), 32'd0);

    // single request, max operand
    n_conv_en = 0;
    raise(0, 12'hFFF);
    exp_grant(0, 12'hFFF); exp_rsp(0, 16'h4095, 1'b0);
    run_until_drained("drain_single", 1000);
    check_eq("single_conv_en_count", 32'(n_conv_en), 32'd1);

    // fairness: req1 keeps requesting, req2 arrives mid-conversion
    sticky[1] = 1'b1;
    raise(1, 12'h0AB);
    exp_grant(1, 12'h0AB); exp_rsp(1, bin2bcd(12'h0AB), 1'b0);
    exp_grant(2, 12'h02A); exp_rsp(2, 16'h0042, 1'b0);
    exp_grant(1, 12'h0AB); exp_rsp(1, 16'h0171, 1'b0);
    repeat (10) tick();
    raise(2, 12'h02A);
    sticky[1] = 1'b0;
    run_until_drained("drain_fair", 2000);

    // converter never answers: timeout response, then full flush
    mdl_never = 1'b1;
    raise(3, 12'h005);
    exp_grant(3, 12'h005); exp_rsp(3, 16'h0000, 1'b1);
    for (int n = 0; (n < 400) && (eq.size() != 0); n++) tick();
    check_eq("timeout_rsp_seen", 32'(eq.size()), 32'd0);
    check_eq("timeout_latency", 32'(rsp_cyc - gnt_cyc), 32'(TO + 2));
    check_eq("timeout_flush_busy", 32'(busy), 32'd1);
    mdl_never = 1'b0;
    t0 = rsp_cyc;
    raise(0, 12'h010);
    exp_grant(0, 12'h010); exp_rsp(0, 16'h0016, 1'b0);
    run_until_drained("drain_after_timeout", 1500);
    check_eq("flush_hold", 32'((gnt_cyc - t0) >= TO), 32'd1);

    // reset mid-WAIT: dropped request gets no response, flush drains converter
    raise(1, 12'h200);
    exp_grant(1, 12'h200);
    repeat (20) tick();
    check_eq("midwait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_rsp_data", 32'(rsp_data), 32'd0);
    t0 = cyc;
    raise(0, 12'h123);
    exp_grant(0, 12'h123); exp_rsp(0, 16'h0291, 1'b0);
    run_until_drained("drain_after_reset", 1500);
    check_eq("flush_drain_early", 32'((gnt_cyc - t0) < TO), 32'd1);

    // done pulse lands exactly on the watchdog limit: success
    mdl_lat = TO;
    raise(2, 12'h3FF);
    exp_grant(2, 12'h3FF); exp_rsp(2, 16'h1023, 1'b0);
    run_until_drained("drain_coincident", 1500);
    check_eq("coincident_latency", 32'(rsp_cyc - gnt_cyc), 32'(TO + 2));

    repeat (5) tick();
    check_eq("final_queues", 32'(gq.size() + eq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
